mem_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline: data memory with byte/halfword store masking and load extension, plus the MEM/WB pipeline register.
- Sits between the EX/MEM register and the write-back stage.
- Every W-suffixed output feeds the write-back stage directly: RegWrite, MemtoReg select, load data, ALU result, dest reg, PC+4, extended immediate.

---
 rtl/mem_stage.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : MEM stage of a 5-stage MIPS pipeline. Holds the data memory
//             (byte/halfword store lanes, sign/zero load extension) and the
//             MEM/WB pipeline register that feeds write-back.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DM_AW       word-address width; memory depth = 2**DM_AW 32-bit words
//  Ports
//    clk         system clock, all state changes on posedge
//    reset       synchronous active-high reset (clears W register and memory)
//    RegWriteM   register-file write enable of the instruction in MEM
//    MemtoRegM   write-back source select, passed through
//    MemWriteM   store enable
//    MemOpM      access size/sign (000 w, 001 hs, 010 hu, 011 bs, 100 bu)
//    ALUoutM     effective byte address / ALU result
//    WriteDataM  store data
//    AwriteM     destination register
//    PC_4M       PC+4 of the instruction
//    ext_immM    extended immediate
//    *W outputs  MEM inputs delayed by one cycle; RDW is the extended load
//    AlignErrW   misaligned-access flag
//  Build option
//    MEM_ALIGN_CHECK_EN  when defined, misaligned word/half accesses are
//                        flagged on AlignErrW, stores are dropped and loads
//                        return 0. When undefined, low address bits that do
//                        not select a lane are ignored and AlignErrW is 0.
// ============================================================================
module mem_stage #(
    parameter int DM_AW = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic [1:0]  MemtoRegM,
    input  logic        MemWriteM,
    input  logic [2:0]  MemOpM,
    input  logic [31:0] ALUoutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  AwriteM,
    input  logic [31:0] PC_4M,
    input  logic [31:0] ext_immM,
    output logic        RegWriteW,
    output logic [1:0]  MemtoRegW,
    output logic [31:0] RDW,
    output logic [31:0] ALUoutW,
    output logic [4:0]  AwriteW,
    output logic [31:0] PC_4W,
    output logic [31:0] ext_immW,
    output logic        AlignErrW
);

    localparam int         c_DEPTH     = 1 << DM_AW;
    localparam logic [2:0] c_OP_HALF_S = 3'b001;
    localparam logic [2:0] c_OP_HALF_U = 3'b010;
    localparam logic [2:0] c_OP_BYTE_S = 3'b011;
    localparam logic [2:0] c_OP_BYTE_U = 3'b100;

    // ------------------------------------------------------------------
    // Storage and pipeline registers
    // ------------------------------------------------------------------
    logic [31:0] mem_q [c_DEPTH];

    logic        regwrite_q, regwrite_d;
    logic [1:0]  memtoreg_q, memtoreg_d;
    logic [31:0] rd_q,       rd_d;
    logic [31:0] aluout_q,   aluout_d;
    logic [4:0]  awrite_q,   awrite_d;
    logic [31:0] pc4_q,      pc4_d;
    logic [31:0] extimm_q,   extimm_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [DM_AW-1:0] w_idx;
    logic [1:0]       w_off;
    logic             w_is_half;
    logic             w_is_byte;
    logic             w_misalign;
    logic             w_store_en;

    assign w_idx     = ALUoutM[DM_AW+1:2];
    assign w_off     = ALUoutM[1:0];
    assign w_is_half = (MemOpM == c_OP_HALF_S) || (MemOpM == c_OP_HALF_U);
    assign w_is_byte = (MemOpM == c_OP_BYTE_S) || (MemOpM == c_OP_BYTE_U);

    // Address bits above the memory depth only alias; fold them away so
    // they are visibly consumed.
    if (DM_AW < 30) begin : g_addr_hi
        logic w_unused_addr_hi;
        assign w_unused_addr_hi = ^ALUoutM[31:DM_AW+2];
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Bytes can never be misaligned; unused encodings 101-111 behave as word.
    logic w_access;
    logic alignerr_q, alignerr_d;

    assign w_misalign = w_is_half ? w_off[0]
                                  : (!w_is_byte && (w_off != 2'b00));
    // Only loads (write-back from memory) and stores count as accesses;
    // other instructions carry an arbitrary ALU result on the address bus.
    assign w_access   = MemWriteM || (MemtoRegM == 2'b01);
    assign alignerr_d = w_misalign && w_access;
    assign AlignErrW  = alignerr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            alignerr_q <= 1'b0;
        end else begin
            alignerr_q <= alignerr_d;
        end
    end
`else
    assign w_misalign = 1'b0;
    assign AlignErrW  = 1'b0;
`endif

    assign w_store_en = MemWriteM && !w_misalign;

    // ------------------------------------------------------------------
    // Store lane enables and replicated write data. Replicating the low
    // byte/half across the word lets every lane take the same slice of
    // w_wdata, so only the enables depend on the offset.
    // ------------------------------------------------------------------
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = WriteDataM;
        if (w_is_byte) begin
            w_be[w_off] = 1'b1;
            w_wdata     = {4{WriteDataM[7:0]}};
        end else if (w_is_half) begin
            w_be    = w_off[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{WriteDataM[15:0]}};
        end else begin
            w_be    = 4'b1111;
        end
        if (!w_store_en) begin
            w_be = 4'b0000;
        end
    end

    // ------------------------------------------------------------------
    // Load path: asynchronous read of the pre-write word, lane extract,
    // then extension.
    // ------------------------------------------------------------------
    logic [31:0] w_rword;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;

    assign w_rword = mem_q[w_idx];
    assign w_half  = w_off[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        case (w_off)
            2'd0:    w_byte = w_rword[7:0];
            2'd1:    w_byte = w_rword[15:8];
            2'd2:    w_byte = w_rword[23:16];
            default: w_byte = w_rword[31:24];
        endcase
    end

    always_comb begin
        case (MemOpM)
            c_OP_HALF_S: w_load_ext = {{16{w_half[15]}}, w_half};
            c_OP_HALF_U: w_load_ext = {16'h0000, w_half};
            c_OP_BYTE_S: w_load_ext = {{24{w_byte[7]}}, w_byte};
            c_OP_BYTE_U: w_load_ext = {24'h000000, w_byte};
            default:     w_load_ext = w_rword;
        endcase
    end

    // ------------------------------------------------------------------
    // MEM/WB next state; the register loads every cycle.
    // ------------------------------------------------------------------
    always_comb begin
        regwrite_d = RegWriteM;
        memtoreg_d = MemtoRegM;
        rd_d       = w_misalign ? 32'h0000_0000 : w_load_ext;
        aluout_d   = ALUoutM;
        awrite_d   = AwriteM;
        pc4_d      = PC_4M;
        extimm_d   = ext_immM;
    end

    // Reset clears the whole memory as well as the pipeline register and
    // wins over any store presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
            regwrite_q <= 1'b0;
            memtoreg_q <= 2'b00;
            rd_q       <= 32'h0000_0000;
            aluout_q   <= 32'h0000_0000;
            awrite_q   <= 5'd0;
            pc4_q      <= 32'h0000_0000;
            extimm_q   <= 32'h0000_0000;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    mem_q[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            rd_q       <= rd_d;
            aluout_q   <= aluout_d;
            awrite_q   <= awrite_d;
            pc4_q      <= pc4_d;
            extimm_q   <= extimm_d;
        end
    end

    assign RegWriteW = regwrite_q;
    assign MemtoRegW = memtoreg_q;
    assign RDW       = rd_q;
    assign ALUoutW   = aluout_q;
    assign AwriteW   = awrite_q;
    assign PC_4W     = pc4_q;
    assign ext_immW  = extimm_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage. Each issued instruction
//             pushes its expected W-stage values into a queue; they are
//             popped and compared one cycle later. A behavioural memory
//             model supplies expected load data.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_mem_stage;

    localparam int TB_AW = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM;
    logic [1:0]  MemtoRegM;
    logic        MemWriteM;
    logic [2:0]  MemOpM;
    logic [31:0] ALUoutM;
    logic [31:0] WriteDataM;
    logic [4:0]  AwriteM;
    logic [31:0] PC_4M;
    logic [31:0] ext_immM;
    logic        RegWriteW;
    logic [1:0]  MemtoRegW;
    logic [31:0] RDW;
    logic [31:0] ALUoutW;
    logic [4:0]  AwriteW;
    logic [31:0] PC_4W;
    logic [31:0] ext_immW;
    logic        AlignErrW;

    mem_stage #(.DM_AW(TB_AW)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteM  (RegWriteM),
        .MemtoRegM  (MemtoRegM),
        .MemWriteM  (MemWriteM),
        .MemOpM     (MemOpM),
        .ALUoutM    (ALUoutM),
        .WriteDataM (WriteDataM),
        .AwriteM    (AwriteM),
        .PC_4M      (PC_4M),
        .ext_immM   (ext_immM),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .RDW        (RDW),
        .ALUoutW    (ALUoutW),
        .AwriteW    (AwriteW),
        .PC_4W      (PC_4W),
        .ext_immW   (ext_immW),
        .AlignErrW  (AlignErrW)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [1:0]  m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  aw;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic        aerr;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl [1 << TB_AW];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] pc_r     = 32'h0000_0100;

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
`ifdef MEM_ALIGN_CHECK_EN
        if (op == 3'b001 || op == 3'b010) return off[0];
        if (op == 3'b011 || op == 3'b100) return 1'b0;
        return off != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] op,
                                               input logic [1:0] off);
        logic [31:0] sh;
        logic [15:0] h;
        sh = w >> {off, 3'b000};
        h  = off[1] ? w[31:16] : w[15:0];
        case (op)
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return {16'h0, h};
            3'b011:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'h0, sh[7:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [2:0] op,
                                                input logic [1:0] off, input logic [31:0] d);
        if (op == 3'b001 || op == 3'b010)
            return off[1] ? {d[15:0], w[15:0]} : {w[31:16], d[15:0]};
        if (op == 3'b011 || op == 3'b100) begin
            case (off)
                2'd0:    return {w[31:8], d[7:0]};
                2'd1:    return {w[31:16], d[7:0], w[7:0]};
                2'd2:    return {w[31:24], d[7:0], w[15:0]};
                default: return {d[7:0], w[23:0]};
            endcase
        end
        return d;
    endfunction

    task automatic compare_one();
        exp_t e;
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check_val("RegWriteW", {31'b0, RegWriteW}, {31'b0, e.rw});
        check_val("MemtoRegW", {30'b0, MemtoRegW}, {30'b0, e.m2r});
        check_val("RDW",       RDW,                e.rd);
        check_val("ALUoutW",   ALUoutW,            e.alu);
        check_val("AwriteW",   {27'b0, AwriteW},   {27'b0, e.aw});
        check_val("PC_4W",     PC_4W,              e.pc4);
        check_val("ext_immW",  ext_immW,           e.imm);
        check_val("AlignErrW", {31'b0, AlignErrW}, {31'b0, e.aerr});
    endtask

    // Drive one instruction at the falling edge after checking the previous
    // one; expected results are built from the model before it is updated.
    task automatic issue(input logic rst, input logic rw, input logic [1:0] m2r,
                         input logic mw, input logic [2:0] op, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] aw,
                         input logic [31:0] pc4, input logic [31:0] imm,
                         input bit lit_en, input logic [31:0] lit_rd);
        exp_t        e;
        int          idx;
        logic        mis;
        logic [31:0] word;
        @(negedge clk);
        compare_one();
        reset = rst; RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw; MemOpM = op;
        ALUoutM = alu; WriteDataM = wd; AwriteM = aw; PC_4M = pc4; ext_immM = imm;
        if (rst) begin
            e = '0;
            for (int i = 0; i < (1 << TB_AW); i++) mdl[i] = 32'h0;
        end else begin
            idx    = int'(alu[TB_AW+1:2]);
            word   = mdl[idx];
            mis    = is_misaligned(op, alu[1:0]);
            e.rw   = rw;
            e.m2r  = m2r;
            e.rd   = mis ? 32'h0 : model_load(word, op, alu[1:0]);
            if (lit_en) e.rd = lit_rd;
            e.alu  = alu;
            e.aw   = aw;
            e.pc4  = pc4;
            e.imm  = imm;
            e.aerr = mis && (mw || m2r == 2'b01);
            if (mw && !mis) mdl[idx] = model_store(word, op, alu[1:0], wd);
        end
        sb_q.push_back(e);
    endtask

    task automatic ld(input logic [2:0] op, input logic [31:0] addr,
                      input bit lit_en, input logic [31:0] lit_rd);
        pc_r += 4;
        issue(1'b0, 1'b1, 2'b01, 1'b0, op, addr, 32'h0, 5'd8, pc_r, 32'h0, lit_en, lit_rd);
    endtask

    task automatic st(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] d);
        pc_r += 4;
        issue(1'b0, 1'b0, 2'b00, 1'b1, op, addr, d, 5'd0, pc_r, addr, 1'b0, 32'h0);
    endtask

    initial begin
        logic        r_rw, r_mw;
        logic [1:0]  r_m2r;
        logic [2:0]  r_op;
        logic [4:0]  r_aw;
        logic [31:0] r_alu;

        reset = 1'b1; RegWriteM = 1'b0; MemtoRegM = 2'b00; MemWriteM = 1'b0;
        MemOpM = 3'b000; ALUoutM = 32'h0; WriteDataM = 32'h0; AwriteM = 5'd0;
        PC_4M = 32'h0; ext_immM = 32'h0;

        // Reset, then first load from a cleared memory
        issue(1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
        issue(1'b0, 1'b1, 2'b01, 1'b0, 3'b000, 32'h0, 32'h0, 5'd5, 32'h104, 32'h7, 1'b1, 32'h0);

        // Sub-word load extraction and extension
        st(3'b000, 32'h10, 32'h8899AABB);
        ld(3'b011, 32'h10, 1'b1, 32'hFFFFFFBB);
        ld(3'b100, 32'h11, 1'b1, 32'h000000AA);
        ld(3'b001, 32'h12, 1'b1, 32'hFFFF8899);
        ld(3'b010, 32'h10, 1'b1, 32'h0000AABB);

        // Sub-word store lane masking
        st(3'b000, 32'h20, 32'h11223344);
        st(3'b011, 32'h23, 32'h123456EE);
        st(3'b001, 32'h20, 32'hABCD5566);
        ld(3'b000, 32'h20, 1'b1, 32'hEE225566);

        // Same-edge store and read of one word: old data, then new data
        pc_r += 4;
        issue(1'b0, 1'b1, 2'b01, 1'b1, 3'b000, 32'h20, 32'hCAFEF00D, 5'd9, pc_r, 32'h0,
              1'b1, 32'hEE225566);
        ld(3'b000, 32'h20, 1'b1, 32'hCAFEF00D);

        // Store and register write coincident with reset are both lost
        issue(1'b1, 1'b1, 2'b01, 1'b1, 3'b000, 32'h30, 32'hDEADBEEF, 5'd3, 32'h200, 32'h5,
              1'b0, 32'h0);
        ld(3'b000, 32'h30, 1'b1, 32'h0);
        ld(3'b000, 32'h20, 1'b1, 32'h0);

        // Pass-through of the non-memory fields
        issue(1'b0, 1'b1, 2'b10, 1'b0, 3'b000, 32'h44, 32'h0, 5'd31, 32'h00003004,
              32'hFFFF8000, 1'b0, 32'h0);

        // Address aliasing above the memory depth
        st(3'b000, 32'h1000, 32'h13579BDF);
        ld(3'b000, 32'h0, 1'b1, 32'h13579BDF);

        // Misaligned word store and half load
        st(3'b000, 32'h42, 32'h0BADF00D);
        ld(3'b000, 32'h40, 1'b0, 32'h0);
        ld(3'b001, 32'h41, 1'b0, 32'h0);
        ld(3'b010, 32'h43, 1'b0, 32'h0);

        // Random mix over a small, aliasing address window
        for (int i = 0; i < 60; i++) begin
            r_rw  = 1'($urandom_range(0, 1));
            r_mw  = 1'($urandom_range(0, 1));
            r_m2r = 2'($urandom_range(0, 3));
            r_op  = 3'($urandom_range(0, 7));
            r_aw  = 5'($urandom_range(0, 31));
            r_alu = $urandom & 32'h0000_301F;
            issue(1'b0, r_rw, r_m2r, r_mw, r_op, r_alu, $urandom, r_aw, $urandom, $urandom,
                  1'b0, 32'h0);
        end

        // Drain the last pending result
        @(negedge clk);
        compare_one();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
